// File: rtl/rand_vec_pkg.sv
// Shared definitions for the LFSR stimulus source: FSM states and the
// maximal-length feedback masks for the supported ISCAS85 input widths.
package rand_vec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned C432_VEC_WIDTH = 36;
    localparam int unsigned C499_VEC_WIDTH = 41;
    localparam int unsigned C880_VEC_WIDTH = 60;

    // Fibonacci masks: x^36+x^25+1, x^41+x^38+1, x^60+x^59+1
    localparam logic [C432_VEC_WIDTH-1:0] TAPS_C432 = 36'h801000000;
    localparam logic [C499_VEC_WIDTH-1:0] TAPS_C499 = 41'h12000000000;
    localparam logic [C880_VEC_WIDTH-1:0] TAPS_C880 = 60'hC00000000000000;

    localparam logic [C432_VEC_WIDTH-1:0] DEFAULT_SEED = 36'h000000001;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with seed load and advance enable; a zero seed is
// replaced by DEFAULT_SEED so the register can never lock up at all-zero.
module lfsr_core #(
    parameter int unsigned           WIDTH        = 36,
    parameter logic [WIDTH-1:0]      TAPS         = 36'h801000000,
    parameter logic [WIDTH-1:0]      DEFAULT_SEED = 36'h000000001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= DEFAULT_SEED;
        end else if (load) begin
            lfsr <= (seed == '0) ? DEFAULT_SEED : seed;
        end else if (advance) begin
            lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
        end
    end

    assign value = lfsr;

endmodule

// File: rtl/rand_vec_gen.sv
// Pseudo-random vector source: emits num_vec LFSR vectors over a valid/ready
// handshake, then pulses done for one cycle. LFSR state persists across runs.
module rand_vec_gen
    import rand_vec_pkg::*;
#(
    parameter int unsigned               VEC_WIDTH    = C432_VEC_WIDTH,
    parameter logic [VEC_WIDTH-1:0]      TAPS         = TAPS_C432,
    parameter int unsigned               CNT_WIDTH    = 20,
    parameter logic [VEC_WIDTH-1:0]      DEFAULT_SEED = rand_vec_pkg::DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [VEC_WIDTH-1:0] seed,
    input  logic                 seed_load,
    input  logic [CNT_WIDTH-1:0] num_vec,
    input  logic                 start,
    output logic [VEC_WIDTH-1:0] vec_out,
    output logic                 vec_valid,
    input  logic                 vec_ready,
    output logic [CNT_WIDTH-1:0] vec_idx,
    output logic                 busy,
    output logic                 done
);

    state_t               state;
    state_t               state_nx;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] idx;
    logic                 xfer;
    logic                 last;

    assign xfer = (state == RUN) && vec_ready;
    assign last = (idx == count - CNT_WIDTH'(1));

    lfsr_core #(
        .WIDTH        (VEC_WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    ((state == IDLE) && seed_load),
        .seed    (seed),
        .advance (xfer),
        .value   (vec_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer && last) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The final transfer leaves idx on the last emitted index.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            idx   <= '0;
        end else if ((state == IDLE) && start && (num_vec != '0)) begin
            count <= num_vec;
            idx   <= '0;
        end else if (xfer && !last) begin
            idx <= idx + CNT_WIDTH'(1);
        end
    end

    assign vec_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign vec_idx   = idx;

endmodule

// File: tb/tb_rand_vec_gen.sv
// Self-checking bench for rand_vec_gen against a polynomial-level LFSR model.
module tb_rand_vec_gen;

    localparam int unsigned W = 36;
    localparam int unsigned C = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] seed = '0;
    logic         seed_load = 1'b0;
    logic [C-1:0] num_vec = '0;
    logic         start = 1'b0;
    logic [W-1:0] vec_out;
    logic         vec_valid;
    logic         vec_ready = 1'b0;
    logic [C-1:0] vec_idx;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] m;

    rand_vec_gen #(
        .VEC_WIDTH (W),
        .CNT_WIDTH (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed      (seed),
        .seed_load (seed_load),
        .num_vec   (num_vec),
        .start     (start),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // x^36 + x^25 + 1: new LSB is the XOR of the two oldest tap positions.
    function automatic logic [W-1:0] step(input logic [W-1:0] s);
        logic fb;
        fb = s[35] ^ s[24];
        return {s[34:0], fb};
    endfunction

    function automatic logic [W-1:0] seeded(input logic [W-1:0] s);
        return (s == 0) ? 36'h000000001 : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input int n, input bit load, input logic [W-1:0] sd, input bit bp);
        int  got;
        int  cycles;
        bit  rdy;
        if (load) m = seeded(sd);
        seed = sd; seed_load = load; num_vec = C'(n); start = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b0;
        got = 0; cycles = 0;
        while (got < n && cycles < 20 * n + 20) begin
            rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            vec_ready = rdy;
            start     = 1'($urandom_range(0, 1));
            seed_load = 1'($urandom_range(0, 1));
            seed      = {4'($urandom), 32'($urandom)};
            num_vec   = C'($urandom);
            check("run_valid", 64'(vec_valid), 64'(1));
            check("run_busy", 64'(busy), 64'(1));
            check("run_vec", 64'(vec_out), 64'(m));
            check("run_idx", 64'(vec_idx), 64'(got));
            tick();
            if (rdy) begin
                m = step(m);
                got++;
            end
            cycles++;
        end
        start = 1'b0; seed_load = 1'b0;
        check("run_len", 64'(got), 64'(n));
        check("done_pulse", 64'(done), 64'(1));
        check("done_valid", 64'(vec_valid), 64'(0));
        check("done_busy", 64'(busy), 64'(0));
        check("done_idx", 64'(vec_idx), 64'(n - 1));
        start = 1'b1; seed_load = 1'b1; seed = {4'($urandom), 32'($urandom)}; num_vec = 5;
        tick();
        start = 1'b0; seed_load = 1'b0;
        check("after_done", 64'(done), 64'(0));
        check("after_valid", 64'(vec_valid), 64'(0));
        check("after_vec", 64'(vec_out), 64'(m));
    endtask

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0;
        m = 36'h000000001;
        check("rst_valid", 64'(vec_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_idx", 64'(vec_idx), 64'(0));
        check("rst_vec", 64'(vec_out), 64'(36'h000000001));

        // Seed and step: 1,2,4,8
        do_run(4, 1'b1, 36'h000000001, 1'b0);

        // Feedback taps with spec-given constants
        seed = 36'h800000000; seed_load = 1'b1; num_vec = 2; start = 1'b1; vec_ready = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b0;
        check("tap1_v0", 64'(vec_out), 64'(36'h800000000));
        tick();
        check("tap1_v1", 64'(vec_out), 64'(36'h000000001));
        tick();
        check("tap1_done", 64'(done), 64'(1));
        tick();
        seed = 36'h801000000; seed_load = 1'b1; num_vec = 2; start = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b0;
        check("tap2_v0", 64'(vec_out), 64'(36'h801000000));
        tick();
        check("tap2_v1", 64'(vec_out), 64'(36'h002000000));
        tick(); tick();
        m = step(step(36'h801000000));
        check("tap2_persist", 64'(vec_out), 64'(m));

        // Backpressure: hold 5 cycles at index 2
        num_vec = 6; start = 1'b1; vec_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("bp_pre_vec", 64'(vec_out), 64'(m));
            tick();
            m = step(m);
        end
        vec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_vec", 64'(vec_out), 64'(m));
            check("bp_hold_idx", 64'(vec_idx), 64'(2));
            check("bp_hold_valid", 64'(vec_valid), 64'(1));
        end
        vec_ready = 1'b1;
        for (int i = 2; i < 6; i++) begin
            check("bp_post_vec", 64'(vec_out), 64'(m));
            check("bp_post_idx", 64'(vec_idx), 64'(i));
            tick();
            m = step(m);
        end
        check("bp_done", 64'(done), 64'(1));
        tick();

        // Zero seed substitution and zero-length run
        do_run(1, 1'b1, 36'h0, 1'b0);
        num_vec = 0; start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", 64'(done), 64'(1));
        check("zero_valid", 64'(vec_valid), 64'(0));
        tick();
        check("zero_done_end", 64'(done), 64'(0));
        check("zero_valid_end", 64'(vec_valid), 64'(0));

        // Mid-run reset at vec_idx 2 of 10
        seed = 36'h123456789; seed_load = 1'b1; num_vec = 10; start = 1'b1; vec_ready = 1'b1;
        tick();
        seed_load = 1'b0; start = 1'b0;
        tick(); tick();
        check("mid_idx", 64'(vec_idx), 64'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m = 36'h000000001;
        check("mid_valid", 64'(vec_valid), 64'(0));
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_idx0", 64'(vec_idx), 64'(0));
        check("mid_done", 64'(done), 64'(0));
        check("mid_vec", 64'(vec_out), 64'(36'h000000001));
        tick();
        check("mid_no_done", 64'(done), 64'(0));

        // Continuation without reseeding, then randomized runs with backpressure
        do_run(3, 1'b0, '0, 1'b0);
        do_run(5, 1'b0, '0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            do_run(int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)),
                   {4'($urandom), 32'($urandom)}, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
